mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage directly downstream of the ALU (EX) stage. Consumes alu_out as a word address, or as a
//  pass-through result. Performs word loads/stores over a req/gnt + rvalid data-memory bus.
//  Stalls EX while an access is outstanding and produces a registered MEM/WB result plus forwarding data.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ+RESP before aborting with a bus error (>=2)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous, active-low reset
//  ex_valid       in   1   EX presents an instruction
//  ex_ready       out  1   stage can accept; high exactly when state==IDLE
//  ex_alu_out     in   32  ALU result: address for load/store, else result
//  ex_store_data  in   32  store data (rt)
//  ex_rd          in   5   destination register
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store (ex_mem_read && ex_mem_write treated as load)
//  ex_reg_write   in   1   writes register file
//  flush          in   1   kill current/incoming instruction (branch taken)
//  dmem_req       out  1   memory request
//  dmem_we        out  1   1=store
//  dmem_addr      out  32  word address, [1:0]=0
//  dmem_wdata     out  32  store data
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   load data valid
//  dmem_rdata     in   32  load data
//  wb_valid       out  1   one-cycle pulse: retired instruction
//  wb_result      out  32  ALU result or load data
//  wb_rd          out  5   destination
//  wb_reg_write   out  1   gated: 0 for stores and exceptions
//  wb_exc         out  2   00 none, 01 misaligned, 10 bus timeout
//  fwd_valid      out  1   wb_valid && wb_reg_write
// BEHAVIOUR
//  - Reset: state IDLE; every output and internal register 0; ex_ready=1 after reset deasserts.
//  - Accept = ex_valid && ex_ready && !flush. With flush high, the incoming instruction is dropped.
//  - Non-memory op: wb_* registered on the next edge; latency 1, throughput 1/cycle.
//  - Misaligned load/store (alu_out[1:0]!=0): no dmem_req; retire next cycle with wb_exc=01 and wb_reg_write=0.
//  - FSM IDLE -> REQ on an accepted aligned load/store. In REQ:
//    - dmem_req=1; we, addr and wdata are registered and held stable until the cycle dmem_gnt is high.
//  - REQ + gnt: a store retires next edge (wb_valid=1, reg_write=0) -> IDLE; a load -> RESP, dmem_req drops.
//  - RESP + rvalid: wb_result=rdata, wb_valid=1 next edge -> IDLE. rvalid in the same cycle as gnt is illegal.
//  - dmem_rvalid while in IDLE or REQ is ignored; this covers late data after an abort.
//  - Timeout: counter clears on entering REQ and increments every cycle in REQ/RESP. On reaching TIMEOUT_CYCLES:
//    - dmem_req drops and the FSM returns to IDLE;
//    - retire with wb_exc=10 and wb_reg_write=0.
//  - flush in REQ before gnt: drop req, -> IDLE, no wb_valid. flush in REQ with gnt same cycle, or in RESP:
//    the access completes on the bus but wb_valid is suppressed; a latched kill bit holds this until IDLE.
//  - wb_valid is a pulse. wb_result, wb_rd and wb_exc hold their last values while wb_valid=0.
//  - rst_n low mid-access aborts immediately: IDLE, dmem_req=0 asynchronously.
// STRUCTURE
//  - Shared package mem_pkg:
//    - FSM state encoding IDLE=2'd0, REQ=2'd1, RESP=2'd2;
//    - exception codes EXC_NONE / EXC_MISALIGN / EXC_TIMEOUT;
//    - ALUOp constants (LDST=2'd0, BRANCH=2'd1, RTYPE=2'd2).
//  - One sub-module mem_timeout_counter (clear, enable, expired) with $clog2(TIMEOUT_CYCLES+1) bits.
//    All other logic stays flat.
// TESTING
//  1. R-type stream: alu_out=5,6,7 on 3 consecutive cycles -> wb_valid on 3 consecutive cycles with
//     wb_result=5,6,7; ex_ready stays 1.
//  2. Store addr=0x100, data=0xDEADBEEF, gnt after 2 cycles -> req held 3 cycles with stable addr/wdata;
//     wb_valid 1 cycle later, wb_reg_write=0.
//  3. Load addr=0x104, gnt immediate, rvalid 3 cycles later with rdata=0x12345678 -> wb_result=0x12345678,
//     fwd_valid=1; ex_ready=0 throughout.
//  4. Load addr=0x102 -> no dmem_req; wb_exc=01, wb_reg_write=0 one cycle later.
//  5. TIMEOUT_CYCLES=4, gnt never asserted -> req drops after 4 cycles, wb_exc=10;
//     a later stray rvalid has no effect.
//  6. flush in REQ before gnt -> req drops, no wb_valid. rst_n low during RESP -> all outputs 0 immediately,
//     ex_ready=1 after release.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM encoding, exception codes, ALUOp values.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    localparam logic [1:0] ALUOP_LDST   = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;

    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Cycle counter bounding one data-memory access; expired_o marks the last allowed cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: clear wins over increment
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {W{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // this cycle completes the TIMEOUT_CYCLES-th cycle of the access
    assign expired_o = enable_i && (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/gnt + rvalid bus, with a registered MEM/WB result.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [1:0]  wb_exc,
    output logic        fwd_valid
);

    mem_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        kill_q, kill_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic [1:0]  wb_exc_q, wb_exc_d;
    logic        fwd_q, fwd_d;

    logic accept_s, is_mem_s, aligned_s, start_s;
    logic cnt_en_s, expired_s;

    assign accept_s  = ex_valid && (state_q == IDLE) && !flush;
    assign is_mem_s  = ex_mem_read || ex_mem_write;
    assign aligned_s = is_word_aligned(ex_alu_out[1:0]);
    assign start_s   = accept_s && is_mem_s && aligned_s;
    assign cnt_en_s  = (state_q == REQ) || (state_q == RESP);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (start_s),
        .enable_i  (cnt_en_s),
        .expired_o (expired_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state; a grant or response takes priority over flush and timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) state_d = REQ;
                else         state_d = IDLE;
            end
            REQ: begin
                if (dmem_gnt)       state_d = we_q ? IDLE : RESP;
                else if (flush)     state_d = IDLE;
                else if (expired_s) state_d = IDLE;
                else                state_d = REQ;
            end
            RESP: begin
                if (dmem_rvalid || expired_s) state_d = IDLE;
                else                          state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath and retirement; wb_* only change when something retires
    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        kill_d      = kill_q;
        wb_valid_d  = 1'b0;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = wb_rw_q;
        wb_exc_d    = wb_exc_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept_s) begin
                    we_d    = ex_mem_write && !ex_mem_read;
                    addr_d  = ex_alu_out;
                    wdata_d = ex_store_data;
                    rd_d    = ex_rd;
                    rw_d    = ex_reg_write;
                    if (!is_mem_s || !aligned_s) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = ex_alu_out;
                        wb_rd_d     = ex_rd;
                        wb_rw_d     = is_mem_s ? 1'b0 : ex_reg_write;
                        wb_exc_d    = is_mem_s ? EXC_MISALIGN : EXC_NONE;
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_q && !flush) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = addr_q;
                        wb_rd_d     = rd_q;
                        wb_rw_d     = 1'b0;
                        wb_exc_d    = EXC_NONE;
                    end else begin
                        kill_d = flush;
                    end
                end else if (expired_s && !flush) begin
                    wb_valid_d  = 1'b1;
                    wb_result_d = addr_q;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = 1'b0;
                    wb_exc_d    = EXC_TIMEOUT;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            RESP: begin
                kill_d = kill_q || flush;
                if (kill_q || flush) begin
                    wb_valid_d = 1'b0;
                end else if (dmem_rvalid) begin
                    wb_valid_d  = 1'b1;
                    wb_result_d = dmem_rdata;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = rw_q;
                    wb_exc_d    = EXC_NONE;
                end else if (expired_s) begin
                    wb_valid_d  = 1'b1;
                    wb_result_d = addr_q;
                    wb_rd_d     = rd_q;
                    wb_rw_d     = 1'b0;
                    wb_exc_d    = EXC_TIMEOUT;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                kill_d = 1'b0;
            end
        endcase
        fwd_d = wb_valid_d && wb_rw_d;
    end

    // datapath and MEM/WB registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            kill_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= 32'h0000_0000;
            wb_rd_q     <= 5'd0;
            wb_rw_q     <= 1'b0;
            wb_exc_q    <= EXC_NONE;
            fwd_q       <= 1'b0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            kill_q      <= kill_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            wb_exc_q    <= wb_exc_d;
            fwd_q       <= fwd_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign dmem_req     = (state_q == REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_exc       = wb_exc_q;
    assign fwd_valid    = fwd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle bus timeout.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_out, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, flush;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_write, fwd_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_exc(wb_exc), .fwd_valid(fwd_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rd_en, input logic wr_en, input logic rw);
        ex_valid = 1'b1; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
        ex_mem_read = rd_en; ex_mem_write = wr_en; ex_reg_write = rw;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_store_data = 32'h0BAD_0BAD;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        ex_alu_out = 32'h0; ex_rd = 5'd0;
        idle_ex();
        @(negedge clk); @(negedge clk);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_fwd", {31'd0, fwd_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);

        // 1. R-type stream
        for (int i = 0; i < 3; i++) begin
            issue(32'd5 + 32'(i), 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
            step();
            chk("rt_valid", {31'd0, wb_valid}, 32'd1);
            chk("rt_result", wb_result, 32'd5 + 32'(i));
            chk("rt_rd", {27'd0, wb_rd}, 32'd3);
            chk("rt_fwd", {31'd0, fwd_valid}, 32'd1);
            chk("rt_ready", {31'd0, ex_ready}, 32'd1);
        end
        idle_ex();
        step();
        chk("rt_pulse", {31'd0, wb_valid}, 32'd0);
        chk("rt_hold", wb_result, 32'd7);

        // 2. store, gnt in the third REQ cycle
        issue(32'h100, 32'hDEAD_BEEF, 5'd1, 1'b0, 1'b1, 1'b0);
        step();
        idle_ex();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dmem_gnt = 1'b1;
            chk("st_req", {31'd0, dmem_req}, 32'd1);
            chk("st_we", {31'd0, dmem_we}, 32'd1);
            chk("st_addr", dmem_addr, 32'h100);
            chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
            chk("st_ready", {31'd0, ex_ready}, 32'd0);
            chk("st_novalid", {31'd0, wb_valid}, 32'd0);
            step();
        end
        dmem_gnt = 1'b0;
        chk("st_req_off", {31'd0, dmem_req}, 32'd0);
        chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("st_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("st_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("st_exc", {30'd0, wb_exc}, 32'd0);
        chk("st_ready_back", {31'd0, ex_ready}, 32'd1);

        // 3. load, gnt immediate, rvalid three cycles after gnt
        issue(32'h104, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h104);
        chk("ld_ready0", {31'd0, ex_ready}, 32'd0);
        step();
        dmem_gnt = 1'b0;
        chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("ld_ready1", {31'd0, ex_ready}, 32'd0);
        step();
        chk("ld_ready2", {31'd0, ex_ready}, 32'd0);
        chk("ld_wait", {31'd0, wb_valid}, 32'd0);
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        chk("ld_ready3", {31'd0, ex_ready}, 32'd0);
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ld_result", wb_result, 32'h1234_5678);
        chk("ld_rd", {27'd0, wb_rd}, 32'd7);
        chk("ld_fwd", {31'd0, fwd_valid}, 32'd1);
        chk("ld_exc", {30'd0, wb_exc}, 32'd0);
        chk("ld_ready_back", {31'd0, ex_ready}, 32'd1);

        // 4. misaligned load
        issue(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
        step();
        idle_ex();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis_exc", {30'd0, wb_exc}, 32'd1);
        chk("mis_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("mis_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("mis_ready", {31'd0, ex_ready}, 32'd1);

        // 5. timeout with no grant, then a stray rvalid
        issue(32'h200, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        step();
        idle_ex();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", {31'd0, dmem_req}, 32'd1);
            step();
        end
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_valid", {31'd0, wb_valid}, 32'd1);
        chk("to_exc", {30'd0, wb_exc}, 32'd2);
        chk("to_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("to_ready", {31'd0, ex_ready}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
        step();
        dmem_rvalid = 1'b0;
        chk("stray_valid", {31'd0, wb_valid}, 32'd0);
        chk("stray_exc", {30'd0, wb_exc}, 32'd2);
        chk("stray_req", {31'd0, dmem_req}, 32'd0);

        // flush of an incoming instruction in IDLE
        issue(32'd99, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_ex();
        chk("fl_in_valid", {31'd0, wb_valid}, 32'd0);

        // 6a. flush in REQ before gnt
        issue(32'h300, 32'h5555_5555, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        idle_ex();
        chk("fl_req_up", {31'd0, dmem_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("fl_novalid", {31'd0, wb_valid}, 32'd0);
        chk("fl_ready", {31'd0, ex_ready}, 32'd1);

        // 6b. flush in RESP: load completes on the bus but does not retire
        issue(32'h400, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        chk("kill_ready", {31'd0, ex_ready}, 32'd0);
        step();
        dmem_rvalid = 1'b0;
        chk("kill_novalid", {31'd0, wb_valid}, 32'd0);
        chk("kill_ready_back", {31'd0, ex_ready}, 32'd1);

        // 6c. reset asserted during RESP
        issue(32'h500, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("rr_in_resp", {31'd0, ex_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_req", {31'd0, dmem_req}, 32'd0);
        chk("rr_addr", dmem_addr, 32'd0);
        chk("rr_exc", {30'd0, wb_exc}, 32'd0);
        chk("rr_result", wb_result, 32'd0);
        chk("rr_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rr_ready", {31'd0, ex_ready}, 32'd1);
        chk("rr_req_after", {31'd0, dmem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
